cnt_seq_checker: RTL
====================

Name: cnt_seq_checker

Overview:
- Receive-side monitor for the 4-bit up/down binary counter output.
- Samples the count bus each enabled cycle and classifies each step as up, down, hold or bad.
- Locks onto the counting direction, follows legal direction (mode) changes, and reports wrap events and sequence errors.
- Sits next to the counter in unit benches and on-chip as a self-check on the count bus.

Parameters:
- WIDTH, 4, count bus width; must be >= 2.
- LOCK_CNT, 3, consecutive same-direction steps needed to lock.
- ERR_W, 8, width of the saturating error counter.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_en  input  1  sample enable; 0 freezes all state.
- i_cnt  input  WIDTH  observed count value.
- o_locked  output  1  direction lock achieved.
- o_dir  output  1  locked direction; 0 = up, 1 = down.
- o_err  output  1  one-cycle pulse per erroneous step while locked.
- o_wrap  output  1  one-cycle pulse on a legal wrap while locked.
- o_err_cnt  output  ERR_W  total errors; saturates at all-ones.
- o_expected  output  WIDTH  predicted next count value while locked; 0 otherwise.

Behaviour:
- Reset (synchronous, dominates i_en):
  - state = IDLE.
  - All outputs are 0, including o_err_cnt.
  - Internal prev, run, cand and errrun are cleared.
- All outputs are registered. A sample presented in cycle N is reflected on the outputs in cycle N+1.
- i_en = 0:
  - No sampling; state and prev are held.
  - o_err and o_wrap are driven 0.
  - o_locked, o_dir, o_expected and o_err_cnt are held.
- Step classification against prev, modulo 2^WIDTH:
  - UP: i_cnt == prev+1.
  - DN: i_cnt == prev-1.
  - HOLD: i_cnt == prev.
  - BAD: anything else.
- Every enabled sample updates prev to i_cnt.
- IDLE:
  - First enabled sample captures prev; go to SEARCH with run = 0.
- SEARCH (o_locked = 0):
  - UP/DN matching cand, or run = 0: cand = step direction, run++.
  - UP/DN opposite to cand: cand flips, run = 1.
  - HOLD/BAD: run = 0.
  - When run reaches LOCK_CNT: go to LOCKED, o_dir = cand, errrun = 0.
- LOCKED (o_locked = 1):
  - Step in o_dir: legal; errrun = 0.
    - If the step wraps, pulse o_wrap. Up wrap is prev = 2^WIDTH-1, i_cnt = 0. Down wrap is prev = 0, i_cnt = 2^WIDTH-1.
  - Step opposite to o_dir: legal mode change; o_dir flips, no error, errrun = 0. An opposite-direction wrap step also pulses o_wrap.
  - HOLD or BAD: pulse o_err, o_err_cnt increments (saturating), errrun++.
    - If errrun reaches 2 (two consecutive errors): go to SEARCH with run = 0. o_locked drops in the same output cycle as the second o_err.
- o_expected:
  - prev+1 when o_dir = 0, prev-1 when o_dir = 1, valid only while locked.
  - Wraps modulo 2^WIDTH.
  - Forced to 0 in IDLE and SEARCH.
- o_err_cnt is cleared only by reset; it holds across unlock and relock.
- Reset asserted mid-lock: next cycle all outputs are 0 and state is IDLE; relock needs 1 + LOCK_CNT samples.

Decomposition:
- Shared package cnt_chk_pkg holds:
  - the state encoding: IDLE, SEARCH, LOCKED;
  - the step class encoding: STEP_UP, STEP_DN, STEP_HOLD, STEP_BAD;
  - the consecutive-error limit constant, value 2.
- One natural sub-module, cnt_step_classify:
  - combinational (prev, i_cnt) -> step class plus a wrap flag;
  - WIDTH-parameterised and reused by the counter's own bench.

Test Plan:
- Lock up: reset 1 cycle, then i_cnt = 0,1,2,3 with i_en = 1.
  - o_locked = 1 and o_dir = 0 in the cycle after 3 is sampled; o_expected = 4; o_err = 0 throughout.
- Wrap: locked up, drive 14,15,0,1.
  - o_wrap pulses exactly once, in the cycle after 0 is sampled; no o_err; o_expected goes 15,0,1,2.
- Mode change: locked up, drive 5,6,7,6,5,4.
  - o_dir = 1 in the cycle after the second 6 is sampled; o_locked stays 1; o_err never pulses; o_expected = 3 at the end.
- Single glitch: locked up, drive 3,4,9,10.
  - One o_err pulse, one cycle after 9 is sampled; o_err_cnt = 1; o_locked stays 1.
- Double error and relock: locked up, drive 4,4,4.
  - Two o_err pulses; o_locked = 0 with the second pulse; o_err_cnt = 2.
  - Then 5,6,7 relocks up.
- Saturation, reset and enable (ERR_W = 2):
  - 5 separated errors: o_err_cnt = 3.
  - Assert i_rst while locked: next cycle all outputs are 0.
  - i_en = 0 for 4 cycles with a changing i_cnt: no state change and no pulses.

Source files
------------

// File: rtl/cnt_chk_pkg.sv
// Shared encodings for the count-bus sequence checker and its step classifier.
package cnt_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      STEP_UP   = 2'd0,
      STEP_DN   = 2'd1,
      STEP_HOLD = 2'd2,
      STEP_BAD  = 2'd3
   } step_e;

   typedef struct packed {
      step_e step;
      logic  wrap;
   } step_info_t;

   // Consecutive erroneous steps that drop the lock.
   localparam int unsigned ERR_LIMIT = 2;
   localparam int unsigned ERRRUN_W  = 2;

endpackage

// File: rtl/cnt_step_classify.sv
// Classifies one count step (prev -> cnt) modulo 2^WIDTH and flags legal wraps.
module cnt_step_classify
   import cnt_chk_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] cnt,
   output step_info_t       info_c
);

   logic [WIDTH-1:0] prev_inc;
   logic [WIDTH-1:0] prev_dec;

   assign prev_inc = prev + WIDTH'(1);
   assign prev_dec = prev - WIDTH'(1);

   always_comb begin
      info_c.step = STEP_BAD;
      info_c.wrap = 1'b0;
      if (cnt == prev_inc) begin
         info_c.step = STEP_UP;
         info_c.wrap = (cnt == '0);
      end else if (cnt == prev_dec) begin
         info_c.step = STEP_DN;
         info_c.wrap = (cnt == '1);
      end else if (cnt == prev) begin
         info_c.step = STEP_HOLD;
      end
   end

endmodule

// File: rtl/cnt_seq_checker.sv
// Count-bus monitor: locks onto the counting direction, follows mode changes,
// and reports wraps and sequence errors with a saturating error total.
module cnt_seq_checker
   import cnt_chk_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_cnt,
   output logic             o_locked,
   output logic             o_dir,
   output logic             o_err,
   output logic             o_wrap,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic [WIDTH-1:0] o_expected
);

   localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    prev_q, prev_d;
   logic [RUN_W-1:0]    run_q, run_d;
   logic                cand_q, cand_d;
   logic [ERRRUN_W-1:0] errrun_q, errrun_d;
   logic                locked_q, locked_d;
   logic                dir_q, dir_d;
   logic                err_q, err_d;
   logic                wrap_q, wrap_d;
   logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]    expected_q, expected_d;

   step_info_t info_c;
   logic       moving_c;
   logic       is_dn_c;

   cnt_step_classify #(.WIDTH(WIDTH)) u_classify (
      .prev   (prev_q),
      .cnt    (i_cnt),
      .info_c (info_c)
   );

   assign moving_c = (info_c.step == STEP_UP) || (info_c.step == STEP_DN);
   assign is_dn_c  = (info_c.step == STEP_DN);

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      run_d      = run_q;
      cand_d     = cand_q;
      errrun_d   = errrun_q;
      locked_d   = locked_q;
      dir_d      = dir_q;
      err_d      = 1'b0;
      wrap_d     = 1'b0;
      err_cnt_d  = err_cnt_q;
      expected_d = expected_q;

      if (i_en) begin
         prev_d = i_cnt;
         unique case (state_q)
            IDLE: begin
               state_d = SEARCH;
               run_d   = '0;
            end
            SEARCH: begin
               if (moving_c) begin
                  if ((run_q == '0) || (is_dn_c == cand_q)) begin
                     run_d = run_q + RUN_W'(1);
                  end else begin
                     run_d = RUN_W'(1);
                  end
                  cand_d = is_dn_c;
                  if (run_d == RUN_W'(LOCK_CNT)) begin
                     state_d  = LOCKED;
                     dir_d    = is_dn_c;
                     errrun_d = '0;
                  end
               end else begin
                  run_d = '0;
               end
            end
            LOCKED: begin
               if (moving_c) begin
                  // Either a step in the locked direction or a legal mode change.
                  dir_d    = is_dn_c;
                  errrun_d = '0;
                  wrap_d   = info_c.wrap;
               end else begin
                  err_d    = 1'b1;
                  errrun_d = errrun_q + ERRRUN_W'(1);
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
                  if (errrun_d == ERRRUN_W'(ERR_LIMIT)) begin
                     state_d = SEARCH;
                     run_d   = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         locked_d = (state_d == LOCKED);
         if (locked_d) begin
            expected_d = dir_d ? (i_cnt - WIDTH'(1)) : (i_cnt + WIDTH'(1));
         end else begin
            expected_d = '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         prev_q     <= '0;
         run_q      <= '0;
         cand_q     <= 1'b0;
         errrun_q   <= '0;
         locked_q   <= 1'b0;
         dir_q      <= 1'b0;
         err_q      <= 1'b0;
         wrap_q     <= 1'b0;
         err_cnt_q  <= '0;
         expected_q <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         run_q      <= run_d;
         cand_q     <= cand_d;
         errrun_q   <= errrun_d;
         locked_q   <= locked_d;
         dir_q      <= dir_d;
         err_q      <= err_d;
         wrap_q     <= wrap_d;
         err_cnt_q  <= err_cnt_d;
         expected_q <= expected_d;
      end
   end

   assign o_locked   = locked_q;
   assign o_dir      = dir_q;
   assign o_err      = err_q;
   assign o_wrap     = wrap_q;
   assign o_err_cnt  = err_cnt_q;
   assign o_expected = expected_q;

endmodule
